// File: rtl/local_mem_pipelined_if.sv
// Request/response bus between the core and local_mem_pipelined.
// The master modport is the core side; the slave modport is the memory side.
interface local_mem_pipelined_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 56
);
  logic                    mem_req_valid;
  logic                    mem_req_rw;
  logic [DATA_WIDTH/8-1:0] mem_req_byteen;
  logic [ADDR_WIDTH-1:0]   mem_req_addr;
  logic [DATA_WIDTH-1:0]   mem_req_data;
  logic [TAG_WIDTH-1:0]    mem_req_tag;
  logic                    mem_req_ready;
  logic                    mem_rsp_valid;
  logic [DATA_WIDTH-1:0]   mem_rsp_data;
  logic [TAG_WIDTH-1:0]    mem_rsp_tag;
  logic                    mem_rsp_ready;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
           mem_req_data, mem_req_tag, mem_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
           mem_req_data, mem_req_tag, mem_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
  );
endinterface

// File: rtl/local_mem_pipelined.sv
// Pipelined on-chip memory for the Vortex mem_req/mem_rsp bus.
// Reads travel a LATENCY-1 stage shift pipeline into an in-order response
// FIFO; credits (reads accepted but not yet popped) gate mem_req_ready so the
// FIFO can never overflow. Writes are byte-enabled and produce no response.
// Out-of-range requests are accepted, writes dropped, reads return zero, and
// a sticky flag records the event.
// Optional build macro LOCAL_MEM_PERF_EN adds read/write/stall counters.
module local_mem_pipelined #(
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 26,
  parameter int TAG_WIDTH      = 56,
  parameter int DEPTH_WORDS    = 4096,
  parameter int LATENCY        = 4,
  parameter int RSP_FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  local_mem_pipelined_if.slave bus,
  output logic                 mem_idle,
  output logic                 tb_addr_out_of_bounds
`ifdef LOCAL_MEM_PERF_EN
  ,
  output logic [31:0]          perf_reads,
  output logic [31:0]          perf_writes,
  output logic [31:0]          perf_stall_cycles
`endif
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int PTR_W  = $clog2(RSP_FIFO_DEPTH);
  localparam int CNT_W  = $clog2(RSP_FIFO_DEPTH + 1);
  localparam int STAGES = LATENCY - 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
  } rsp_t;

  logic                  running;
  logic [CNT_W-1:0]      outstanding;
  logic                  req_fire;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  rsp_fire;
  logic                  in_bounds;
  logic [IDX_W-1:0]      idx;
  rsp_t                  rd_entry;
  rsp_t                  push_entry;
  logic                  push_valid;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  rsp_t                  fifo [RSP_FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr;
  logic [PTR_W:0]        rd_ptr;
  logic                  fifo_empty;

  // Request side: ready depends only on registered state, never on rw.
  assign bus.mem_req_ready = running && (outstanding < CNT_W'(RSP_FIFO_DEPTH));
  assign req_fire  = bus.mem_req_valid && bus.mem_req_ready;
  assign rd_fire   = req_fire && !bus.mem_req_rw;
  assign wr_fire   = req_fire &&  bus.mem_req_rw;
  assign in_bounds = bus.mem_req_addr < ADDR_WIDTH'(DEPTH_WORDS);
  assign idx       = bus.mem_req_addr[IDX_W-1:0];

  // Read data is captured in the accept cycle, so a preceding write is seen.
  assign rd_entry.data = in_bounds ? mem[idx] : '0;
  assign rd_entry.tag  = bus.mem_req_tag;

  // Byte-enabled write port; out-of-range writes leave the array untouched.
  // NOTE: the storage array is never reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if (wr_fire && in_bounds) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.mem_req_byteen[b]) mem[idx][b*8 +: 8] <= bus.mem_req_data[b*8 +: 8];
      end
    end
  end

  generate
    if (STAGES > 0) begin : g_pipe
      logic [STAGES-1:0] stage_valid;
      rsp_t              stage_entry [STAGES];

      // Valid bits of the read-latency shift pipeline.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          stage_valid <= '0;
        end else begin
          stage_valid[0] <= rd_fire;
          for (int s = 1; s < STAGES; s++) stage_valid[s] <= stage_valid[s-1];
        end
      end

      // Pipeline payload; meaningful only where the matching valid bit is set.
      always_ff @(posedge clk) begin
        stage_entry[0] <= rd_entry;
        for (int s = 1; s < STAGES; s++) stage_entry[s] <= stage_entry[s-1];
      end

      assign push_valid = stage_valid[STAGES-1];
      assign push_entry = stage_entry[STAGES-1];
    end else begin : g_direct
      assign push_valid = rd_fire;
      assign push_entry = rd_entry;
    end
  endgenerate

  // Response FIFO: outputs are forced to zero while empty so the bus is clean
  // in reset and between responses; the head is stable until popped.
  assign fifo_empty        = (wr_ptr == rd_ptr);
  assign bus.mem_rsp_valid = !fifo_empty;
  assign rsp_fire          = bus.mem_rsp_valid && bus.mem_rsp_ready;
  assign bus.mem_rsp_data  = fifo_empty ? '0 : fifo[rd_ptr[PTR_W-1:0]].data;
  assign bus.mem_rsp_tag   = fifo_empty ? '0 : fifo[rd_ptr[PTR_W-1:0]].tag;

  // FIFO pointers with a wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_valid) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (rsp_fire)   rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // FIFO storage; the credit counter guarantees a free slot on every push.
  always_ff @(posedge clk) begin
    if (push_valid) fifo[wr_ptr[PTR_W-1:0]] <= push_entry;
  end

  // Credits, run flag and sticky out-of-range flag.
  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      running               <= 1'b0;
      outstanding           <= '0;
      tb_addr_out_of_bounds <= 1'b0;
    end else begin
      running <= 1'b1;
      case ({rd_fire, rsp_fire})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
      if (req_fire && !in_bounds) tb_addr_out_of_bounds <= 1'b1;
    end
  end

  assign mem_idle = (outstanding == '0);

`ifdef LOCAL_MEM_PERF_EN
  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_reads        <= '0;
      perf_writes       <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (rd_fire) perf_reads  <= perf_reads + 32'd1;
      if (wr_fire) perf_writes <= perf_writes + 32'd1;
      if (bus.mem_req_valid && !bus.mem_req_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_local_mem_pipelined.sv
// Self-checking bench for local_mem_pipelined: a transaction-level model
// (word array plus a queue of pending reads with due cycles) predicts every
// output each cycle; directed sequences add hand-computed literal checks.
module tb_local_mem_pipelined;
  localparam int DW    = 512;
  localparam int AW    = 26;
  localparam int TW    = 56;
  localparam int DEPTH = 4096;
  localparam int LAT   = 4;
  localparam int FD    = 8;
  localparam int BYTES = DW / 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic mem_idle;
  logic oob;
  always #5 clk = ~clk;

  local_mem_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

`ifdef LOCAL_MEM_PERF_EN
  logic [31:0] perf_reads, perf_writes, perf_stall_cycles;
`endif

  local_mem_pipelined #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
    .DEPTH_WORDS(DEPTH), .LATENCY(LAT), .RSP_FIFO_DEPTH(FD)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .bus                  (bus),
    .mem_idle             (mem_idle),
    .tb_addr_out_of_bounds(oob)
`ifdef LOCAL_MEM_PERF_EN
    ,
    .perf_reads           (perf_reads),
    .perf_writes          (perf_writes),
    .perf_stall_cycles    (perf_stall_cycles)
`endif
  );

  // ---------------- model state ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    int            due;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] model_mem [DEPTH];
  bit            m_running;
  bit            m_oob;
  int            cyc;
  logic [TW-1:0] seen_tags[$];
  int            checks;
  int            failures;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic drive_idle();
    bus.mem_req_valid  = 1'b0;
    bus.mem_req_rw     = 1'b0;
    bus.mem_req_byteen = '0;
    bus.mem_req_addr   = '0;
    bus.mem_req_data   = '0;
    bus.mem_req_tag    = '0;
    bus.mem_rsp_ready  = 1'b0;
  endtask

  // One clock cycle, entered and left at a falling edge: check outputs
  // against the model, drive the next inputs, advance the model.
  task automatic step(input bit v, input bit rw, input logic [BYTES-1:0] be,
                      input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input logic [TW-1:0] tag, input bit rr, output bit acc);
    bit   ev;
    exp_t e;
    int   a;
    ev = (q.size() > 0) && (q[0].due <= cyc);
    check("req_ready", DW'(bus.mem_req_ready), DW'(m_running && (q.size() < FD)));
    check("rsp_valid", DW'(bus.mem_rsp_valid), DW'(ev));
    check("mem_idle",  DW'(mem_idle),          DW'(q.size() == 0));
    check("oob_flag",  DW'(oob),               DW'(m_oob));
    if (ev) begin
      check("rsp_data", bus.mem_rsp_data,      q[0].data);
      check("rsp_tag",  DW'(bus.mem_rsp_tag),  DW'(q[0].tag));
    end
    bus.mem_req_valid  = v;
    bus.mem_req_rw     = rw;
    bus.mem_req_byteen = be;
    bus.mem_req_addr   = addr;
    bus.mem_req_data   = data;
    bus.mem_req_tag    = tag;
    bus.mem_rsp_ready  = rr;
    acc = v && m_running && (q.size() < FD);
    if (ev && rr) begin
      seen_tags.push_back(bus.mem_rsp_tag);
      void'(q.pop_front());
    end
    if (acc) begin
      a = int'(addr);
      if (addr >= AW'(DEPTH)) m_oob = 1'b1;
      if (rw) begin
        if (addr < AW'(DEPTH))
          for (int b = 0; b < BYTES; b++)
            if (be[b]) model_mem[a][b*8 +: 8] = data[b*8 +: 8];
      end else begin
        e.data = (addr < AW'(DEPTH)) ? model_mem[a] : '0;
        e.tag  = tag;
        e.due  = cyc + LAT;
        q.push_back(e);
      end
    end
    m_running = 1'b1;
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input bit rr);
    bit a;
    step(1'b0, 1'b0, '0, '0, '0, '0, rr, a);
  endtask

  // Hold a request until the model says it is accepted (bounded).
  task automatic do_req(input bit rw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [BYTES-1:0] be, input logic [TW-1:0] tag, input bit rr);
    bit acc;
    int n;
    n = 0;
    do begin
      step(1'b1, rw, be, addr, data, tag, rr, acc);
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL req_accept_timeout: got not-accepted expected accepted");
    end
    drive_idle();
  endtask

  // Directed read with literal expectations at exactly accept+LAT.
  task automatic read_pin(input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                          input logic [DW-1:0] exp_data, input string name);
    do_req(1'b0, addr, '0, '0, tag, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check({name, "_not_early"}, DW'(bus.mem_rsp_valid), DW'(0));
    idle(1'b0);
    check({name, "_valid"}, DW'(bus.mem_rsp_valid), DW'(1));
    check({name, "_data"},  bus.mem_rsp_data,        exp_data);
    check({name, "_tag"},   DW'(bus.mem_rsp_tag),    DW'(tag));
    idle(1'b1);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    drive_idle();
    q.delete();
    m_running = 1'b0;
    m_oob     = 1'b0;
    #1;
    check("rst_req_ready", DW'(bus.mem_req_ready), DW'(0));
    check("rst_rsp_valid", DW'(bus.mem_rsp_valid), DW'(0));
    check("rst_rsp_data",  bus.mem_rsp_data,       DW'(0));
    check("rst_rsp_tag",   DW'(bus.mem_rsp_tag),   DW'(0));
    check("rst_mem_idle",  DW'(mem_idle),          DW'(1));
    check("rst_oob",       DW'(oob),               DW'(0));
    repeat (2) @(negedge clk);
    cyc += 2;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] w904;
    int            k;
    int            acc_cnt;
    int            guard;
    bit            acc;

    checks   = 0;
    failures = 0;
    cyc      = 0;
    drive_idle();
    #2;
    apply_reset();

    // Reset release: ready rises one cycle later.
    idle(1'b0);
    check("post_rst_ready", DW'(bus.mem_req_ready), DW'(1));
    check("post_rst_idle",  DW'(mem_idle),          DW'(1));

    // Preload the region used by the random phase.
    for (int i = 0; i < 32; i++) do_req(1'b1, AW'(i), rand_word(), '1, '0, 1'b0);

    // Full write then read, latency and data pinned.
    do_req(1'b1, AW'(16), {BYTES{8'hA5}}, '1, '0, 1'b0);
    read_pin(AW'(16), TW'(3), {BYTES{8'hA5}}, "wr_rd");

    // Partial write of byte 0 only.
    do_req(1'b1, AW'(16), {{(BYTES-1){8'h00}}, 8'h5A}, BYTES'(1), '0, 1'b0);
    read_pin(AW'(16), TW'(4), {{(BYTES-1){8'hA5}}, 8'h5A}, "partial");

    // Credit exhaustion under response backpressure.
    seen_tags.delete();
    k       = 0;
    acc_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 1'b0, '0, AW'(k), '0, TW'(k), 1'b0, acc);
      if (acc) begin
        k++;
        acc_cnt++;
      end
    end
    check("credit_accepted",  DW'(acc_cnt),           DW'(8));
    check("credit_ready_low", DW'(bus.mem_req_ready), DW'(0));
    guard = 0;
    while (k < 10 && guard < 50) begin
      step(1'b1, 1'b0, '0, AW'(k), '0, TW'(k), 1'b1, acc);
      if (acc) k++;
      guard++;
    end
    drive_idle();
    repeat (20) idle(1'b1);
    check("credit_pop_count", DW'(seen_tags.size()), DW'(10));
    for (int i = 0; i < 10 && i < seen_tags.size(); i++)
      check($sformatf("credit_order_%0d", i), DW'(seen_tags[i]), DW'(i));
    check("credit_idle", DW'(mem_idle), DW'(1));

    // Out-of-range read and non-aliasing out-of-range write.
    check("oob_before", DW'(oob), DW'(0));
    read_pin(AW'(4096), TW'(7), '0, "oob_read");
    check("oob_set", DW'(oob), DW'(1));
    w904 = rand_word();
    do_req(1'b1, AW'(904), w904, '1, '0, 1'b0);
    do_req(1'b1, AW'(5000), ~w904, '1, '0, 1'b0);
    read_pin(AW'(904), TW'(8), w904, "no_alias");
    check("oob_sticky", DW'(oob), DW'(1));

    // Randomised traffic with random backpressure.
    for (int c = 0; c < 1500; c++) begin
      logic [AW-1:0] addr;
      addr = ($urandom % 16 == 0) ? AW'(4096 + $urandom % 200) : AW'($urandom % 32);
      step(($urandom % 3) != 0, $urandom % 2, BYTES'({$urandom, $urandom}), addr,
           rand_word(), TW'({$urandom, $urandom}), ($urandom % 4) != 0, acc);
    end
    drive_idle();
    repeat (30) idle(1'b1);
    check("drain_idle", DW'(mem_idle), DW'(1));

    // Reset with three reads in flight; nothing stale may emerge.
    for (int i = 0; i < 3; i++) do_req(1'b0, AW'(i), '0, '0, TW'(20 + i), 1'b0);
    apply_reset();
    repeat (15) idle(1'b1);
    check("post_mid_rst_idle", DW'(mem_idle), DW'(1));
    read_pin(AW'(904), TW'(9), w904, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/local_mem_pipelined.md
Name: local_mem_pipelined

Overview:
Synthesizable, parametrised on-chip memory model that serves the Vortex memory request/response bus. It replaces the fixed single-cycle local RAM behind the core wrapper. It adds configurable read latency, multiple outstanding reads with in-order tagged responses, credit-based backpressure, byte-enabled writes and a sticky out-of-bounds flag. It sits directly on the core's mem_req_*/mem_rsp_* ports.

Parameters:
DATA_WIDTH, 512, memory word/bus data width in bits (multiple of 8)
ADDR_WIDTH, 26, word address width on the bus
TAG_WIDTH, 56, request/response tag width
DEPTH_WORDS, 4096, number of implemented words; valid addresses are 0..DEPTH_WORDS-1
LATENCY, 4, read accept-to-earliest-response cycles (>=1)
RSP_FIFO_DEPTH, 8, maximum outstanding reads (power of 2, >=2)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
mem_req_valid  input  1  request valid
mem_req_rw  input  1  1=write, 0=read
mem_req_byteen  input  DATA_WIDTH/8  write byte enables
mem_req_addr  input  ADDR_WIDTH  word address
mem_req_data  input  DATA_WIDTH  write data
mem_req_tag  input  TAG_WIDTH  request tag
mem_req_ready  output  1  request accepted when valid&ready
mem_rsp_valid  output  1  read response valid
mem_rsp_data  output  DATA_WIDTH  read data
mem_rsp_tag  output  TAG_WIDTH  tag of the originating read
mem_rsp_ready  input  1  response consumed when valid&ready
mem_idle  output  1  no reads in flight and response FIFO empty
tb_addr_out_of_bounds  output  1  sticky: an accepted request had addr >= DEPTH_WORDS

Behaviour:
- Reset (reset=0, async): mem_req_ready=0, mem_rsp_valid=0, mem_rsp_data=0, mem_rsp_tag=0, mem_idle=1, tb_addr_out_of_bounds=0. The credit counter, pipeline valids and FIFO pointers clear. Array contents are not reset. All in-flight reads are discarded. Deassertion takes effect at the next clk edge.
- Credits: outstanding = reads accepted but not yet handed off. It counts pipeline entries plus FIFO entries, range 0..RSP_FIFO_DEPTH.
- mem_req_ready = out of reset && outstanding < RSP_FIFO_DEPTH. It is combinational from registered state only. Writes also stall when credits are full, to keep ready independent of rw.
- Write accept (cycle T): for each byte i with byteen[i]=1, mem[addr] byte i = data byte i. The update is visible to a read accepted at T+1. No response is generated and outstanding is unchanged.
- Read accept (cycle T): mem[addr] and tag are sampled at T, so write-then-read returns new data. The entry traverses a LATENCY-1 stage shift pipeline, then is written into the FIFO. mem_rsp_valid rises no earlier than T+LATENCY. With an empty FIFO and rsp_ready=1 it rises exactly at T+LATENCY. outstanding increments.
- Responses are strictly in accept order. The FIFO never overflows, because credits bound it.
- Response handshake: valid&ready pops the FIFO and decrements outstanding. Read accept and pop in the same cycle leave outstanding unchanged.
- mem_rsp_valid stays high and data/tag stay stable until popped (no drop under backpressure).
- Out of bounds (addr >= DEPTH_WORDS): the request is still accepted. A write is dropped with no array change. A read returns data=0 with the correct tag at normal latency. tb_addr_out_of_bounds sets the next cycle and holds until reset.
- Address index = addr[clog2(DEPTH_WORDS)-1:0] only after the bounds check passes.
- mem_idle = (outstanding==0).
- Pipelining: one request per cycle sustained when rsp_ready=1 and RSP_FIFO_DEPTH >= LATENCY+1.

Optional Feature:
LOCAL_MEM_PERF_EN. Defined: adds outputs perf_reads[31:0], perf_writes[31:0] and perf_stall_cycles[31:0]. These count accepted reads, accepted writes and cycles with mem_req_valid=1 && mem_req_ready=0. Counters are reset to 0 and wrap at 2^32. Undefined: these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset then idle -> mem_req_ready=1 one cycle after reset release, mem_idle=1, rsp_valid=0, oob=0.
- Write addr 0x10 data all-0xA5 byteen all-1, then read addr 0x10 tag 0x3 next cycle -> rsp_valid at read_T+4, data all-0xA5, tag 0x3.
- Partial write byteen=0x...0001 data byte0=0x5A onto 0xA5 word, read back -> byte0=0x5A, all others 0xA5.
- Hold rsp_ready=0, issue reads tags 0..9 back-to-back -> exactly 8 accepted, ready=0 thereafter. Then rsp_ready=1 -> tags 0..7 return in order, remaining 2 are accepted as credits free, final mem_idle=1.
- Read addr 4096 tag 0x7 -> rsp data=0, tag 0x7, oob=1 sticky until reset. Write addr 5000 does not alias to addr 904 (read 904 unchanged).
- Assert reset mid-stream with 3 reads in flight -> all outputs return to reset values, no stale responses after release.
